word_packer: RTL and testbench

//  Compression-side bit packer: concatenates variable-length codes (0..DATA_W bits each) MSB-first into fixed OUT_W-bit words.

---
 rtl/word_packer.sv | 144 ++++++++++++++
 tb/tb_word_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer.sv
// word_packer: packs variable-length codes MSB-first into fixed OUT_W-bit words.
// The first code of a frame lands in the top bits of the first output word.
// Optional feature macro: WORD_PACKER_STATS_EN adds o_total_bits, a saturating
// count of code bits accepted since reset.
//
// state  | meaning
// ACCUM  | accepting codes, draining full words as they complete
// FLUSH  | frame ended; drain remaining full words, then emit the o_last word
module word_packer #(
   parameter int DATA_W = 34,
   parameter int OUT_W  = 128,
   parameter int LEN_W  = $clog2(DATA_W + 1),
   parameter int CNT_W  = $clog2(OUT_W + DATA_W + 1),
   parameter int BITS_W = $clog2(OUT_W + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_last,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_last,
   output logic [BITS_W-1:0] o_bits
`ifdef WORD_PACKER_STATS_EN
   ,
   output logic [31:0]       o_total_bits
`endif
);

   localparam int BUF_W = OUT_W + DATA_W;
   localparam logic [CNT_W-1:0]  OUT_CNT  = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0]  BUF_CNT  = CNT_W'(BUF_W);
   localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(DATA_W);
   localparam logic [BITS_W-1:0] FULL_BITS = BITS_W'(OUT_W);

   typedef enum logic {ACCUM, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [BUF_W-1:0]  buf_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_c;
   logic [DATA_W-1:0] code_m;
   logic [CNT_W-1:0]  shamt;
   logic              slot_free;
   logic              accept;
   logic              do_drain;
   logic              do_flush;

   // Clamp the length and strip the ignored high bits of the code.
   always_comb begin
      len_c  = (i_len > MAX_LEN) ? MAX_LEN : i_len;
      code_m = i_data & ({DATA_W{1'b1}} >> (MAX_LEN - len_c));
      shamt  = BUF_CNT - cnt_q - CNT_W'(len_c);
   end

   // Next-state and handshake decode; drain takes priority over flush so an
   // exact multiple of OUT_W yields a full word followed by an empty last word.
   always_comb begin
      state_d   = state_q;
      o_ready   = 1'b0;
      accept    = 1'b0;
      do_drain  = 1'b0;
      do_flush  = 1'b0;
      slot_free = !o_valid || i_ready;
      if (slot_free && (cnt_q >= OUT_CNT))
         do_drain = 1'b1;
      case (state_q)
         ACCUM: begin
            o_ready = (cnt_q < OUT_CNT);
            accept  = i_valid && o_ready;
            if (accept && i_last)
               state_d = FLUSH;
         end
         FLUSH: begin
            if (slot_free && !do_drain && (cnt_q <= OUT_CNT)) begin
               do_flush = 1'b1;
               state_d  = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= ACCUM;
      else
         state_q <= state_d;
   end

   // Bit buffer, fill count and registered output stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buf_q   <= '0;
         cnt_q   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_bits  <= '0;
      end else begin
         if (accept) begin
            buf_q <= buf_q | ({{OUT_W{1'b0}}, code_m} << shamt);
            cnt_q <= cnt_q + CNT_W'(len_c);
         end else if (do_drain) begin
            buf_q <= buf_q << OUT_W;
            cnt_q <= cnt_q - OUT_CNT;
         end else if (do_flush) begin
            buf_q <= '0;
            cnt_q <= '0;
         end
         if (do_drain || do_flush) begin
            o_valid <= 1'b1;
            o_data  <= buf_q[BUF_W-1 -: OUT_W];
            o_last  <= do_flush;
            o_bits  <= do_flush ? BITS_W'(cnt_q) : FULL_BITS;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

`ifdef WORD_PACKER_STATS_EN
   logic [31:0] total_q;
   logic [32:0] total_sum;

   always_comb total_sum = {1'b0, total_q} + 33'(len_c);

   // Saturating count of accepted code bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         total_q <= '0;
      else if (accept)
         total_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
   end

   assign o_total_bits = total_q;
`endif

endmodule

// File: tb/tb_word_packer.sv
// Testbench for word_packer: directed scenarios plus random streams checked
// against a bit-queue reference model.
module tb_word_packer;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [33:0]  i_data = '0;
   logic [5:0]   i_len = '0;
   logic         i_last = 1'b0;
   logic         o_valid;
   logic         i_ready = 1'b1;
   logic [127:0] o_data;
   logic         o_last;
   logic [7:0]   o_bits;
`ifdef WORD_PACKER_STATS_EN
   logic [31:0]  o_total_bits;
`endif

   word_packer dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_len   (i_len),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_bits  (o_bits)
`ifdef WORD_PACKER_STATS_EN
      ,
      .o_total_bits (o_total_bits)
`endif
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [127:0] d;
      logic         l;
      logic [7:0]   b;
   } word_t;

   int      total = 0;
   int      bad = 0;
   bit      bitq[$];
   word_t   expq[$];
   word_t   rxq[$];
   longint  tot_bits = 0;
   bit      rnd_mode = 0;
   bit      fixed_ready = 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: pull bits off a flat bit stream, 128 at a time.
   task automatic push_word(input bit last);
      word_t w;
      int    n;
      n = (bitq.size() > 128) ? 128 : bitq.size();
      w.d = '0;
      for (int i = 0; i < n; i++) w.d[127-i] = bitq.pop_front();
      w.l = last;
      w.b = 8'(n);
      expq.push_back(w);
   endtask

   task automatic model_accept(input logic [33:0] d, input logic [5:0] len, input logic last);
      int l;
      l = (len > 34) ? 34 : int'(len);
      for (int b = l - 1; b >= 0; b--) bitq.push_back(d[b]);
      tot_bits += l;
      while (bitq.size() >= 128) push_word(1'b0);
      if (last) push_word(1'b1);
   endtask

   // Monitor: at the falling edge, whatever handshakes are visible complete on the next rising edge.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_valid && i_ready) begin
            word_t r;
            r.d = o_data; r.l = o_last; r.b = o_bits;
            rxq.push_back(r);
            chk("word_expected", 128'(expq.size() != 0), 128'(1));
            if (expq.size() != 0) begin
               word_t e;
               e = expq.pop_front();
               chk("o_data", o_data, e.d);
               chk("o_last", 128'(o_last), 128'(e.l));
               chk("o_bits", 128'(o_bits), 128'(e.b));
            end
         end
         if (i_valid && o_ready) model_accept(i_data, i_len, i_last);
      end
   end

   // Downstream ready driver.
   always @(posedge i_clk) begin
      #1;
      i_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : fixed_ready;
   end

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic send_code(input logic [33:0] d, input logic [5:0] len, input logic last);
      bit acc;
      int n;
      i_valid = 1'b1; i_data = d; i_len = len; i_last = last;
      acc = 0; n = 0;
      while (!acc && n < 300) begin
         @(negedge i_clk);
         acc = o_ready;
         tick();
         n++;
      end
      i_valid = 1'b0;
      chk("send_accepted", 128'(acc), 128'(1));
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (expq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 128'(expq.size()), 128'(0));
   endtask

   task automatic set_ready(input bit r);
      fixed_ready = r;
      tick();
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      tick();
      chk("rst_o_valid", 128'(o_valid), 128'(0));
      chk("rst_o_data", o_data, 128'(0));
      chk("rst_o_last", 128'(o_last), 128'(0));
      chk("rst_o_bits", 128'(o_bits), 128'(0));
      bitq.delete(); expq.delete(); rxq.delete();
      tot_bits = 0;
      tick();
      i_rst_n = 1'b1;
      #1;
      chk("rst_o_ready", 128'(o_ready), 128'(1));
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [33:0]  d;
      logic [63:0]  r;
      logic [127:0] snap;
      logic [8:0]   snap_ctl;
      int           nc;

      // 1. reset
      do_reset();

      // 2. four 32-bit codes, exact multiple; also latency of the completed word
      send_code(34'hAAAA_AAAA, 6'd32, 1'b0);
      send_code(34'hBBBB_BBBB, 6'd32, 1'b0);
      send_code(34'hCCCC_CCCC, 6'd32, 1'b0);
      send_code(34'hDDDD_DDDD, 6'd32, 1'b1);
      chk("latency_n1", 128'(o_valid), 128'(0));
      tick();
      chk("latency_n2", 128'(o_valid), 128'(1));
      wait_empty(50);
      chk("t2_count", 128'(rxq.size()), 128'(2));
      if (rxq.size() == 2) begin
         chk("t2_w0", rxq[0].d, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
         chk("t2_w0_ctl", 128'({rxq[0].l, rxq[0].b}), 128'({1'b0, 8'd128}));
         chk("t2_w1", rxq[1].d, 128'(0));
         chk("t2_w1_ctl", 128'({rxq[1].l, rxq[1].b}), 128'({1'b1, 8'd0}));
      end
      rxq.delete();

      // 3. five 3-bit codes
      for (int i = 0; i < 5; i++) send_code(34'h5, 6'd3, i == 4);
      wait_empty(50);
      chk("t3_count", 128'(rxq.size()), 128'(1));
      if (rxq.size() == 1) begin
         chk("t3_w0", rxq[0].d, {15'b101101101101101, 113'b0});
         chk("t3_w0_ctl", 128'({rxq[0].l, rxq[0].b}), 128'({1'b1, 8'd15}));
      end
      rxq.delete();

      // 4. straddle with 34-bit codes
      for (int i = 0; i < 4; i++) send_code({34{1'b1}}, 6'd34, i == 3);
      wait_empty(50);
      chk("t4_count", 128'(rxq.size()), 128'(2));
      if (rxq.size() == 2) begin
         chk("t4_w0", rxq[0].d, {128{1'b1}});
         chk("t4_w0_ctl", 128'({rxq[0].l, rxq[0].b}), 128'({1'b0, 8'd128}));
         chk("t4_w1", rxq[1].d, {8'hFF, 120'b0});
         chk("t4_w1_ctl", 128'({rxq[1].l, rxq[1].b}), 128'({1'b1, 8'd8}));
      end
      rxq.delete();

      // 5. backpressure
      set_ready(1'b0);
      for (int i = 0; i < 8; i++) begin
         r = {$urandom(), $urandom()};
         send_code(r[33:0], 6'd32, 1'b0);
      end
      snap = o_data;
      snap_ctl = {o_last, o_bits};
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("bp_data_stable", o_data, snap);
         chk("bp_ctl_stable", 128'({o_last, o_bits}), 128'(snap_ctl));
         chk("bp_o_valid", 128'(o_valid), 128'(1));
         chk("bp_o_ready", 128'(o_ready), 128'(0));
      end
      tick();
      set_ready(1'b1);
      send_code(34'h0_0000_00A5, 6'd8, 1'b1);
      wait_empty(50);
      chk("t5_count", 128'(rxq.size()), 128'(3));
      rxq.delete();

      // 6a. masking, zero length, clamped length
      send_code({34{1'b1}}, 6'd5, 1'b0);
      send_code(34'h1_2345_6789, 6'd0, 1'b0);
      send_code(34'h2_AAAA_5555, 6'd40, 1'b1);
      wait_empty(50);
      chk("t6_count", 128'(rxq.size()), 128'(1));
      if (rxq.size() == 1) begin
         chk("t6_w0", rxq[0].d, {5'b11111, 34'h2_AAAA_5555, 89'b0});
         chk("t6_w0_ctl", 128'({rxq[0].l, rxq[0].b}), 128'({1'b1, 8'd39}));
      end
      rxq.delete();
`ifdef WORD_PACKER_STATS_EN
      chk("stats_directed", 128'(o_total_bits), 128'(tot_bits));
`endif

      // 6b. reset while a flush is pending
      set_ready(1'b0);
      for (int i = 0; i < 4; i++) send_code(34'h1234_5678, 6'd32, 1'b0);
      send_code(34'h0_0000_00FF, 6'd8, 1'b1);
      tick();
      chk("pre_rst_o_valid", 128'(o_valid), 128'(1));
      do_reset();
      set_ready(1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         chk("post_rst_no_output", 128'(o_valid), 128'(0));
      end
      tick();
`ifdef WORD_PACKER_STATS_EN
      chk("stats_reset", 128'(o_total_bits), 128'(0));
`endif

      // 6c. random streams
      rnd_mode = 1;
      for (int f = 0; f < 8; f++) begin
         nc = $urandom_range(1, 40);
         for (int i = 0; i < nc; i++) begin
            r = {$urandom(), $urandom()};
            d = r[33:0];
            send_code(d, 6'($urandom_range(0, 40)), i == nc - 1);
            if ($urandom_range(0, 7) == 0) tick();
         end
      end
      wait_empty(3000);
      rnd_mode = 0;
      tick();
`ifdef WORD_PACKER_STATS_EN
      chk("stats_random", 128'(o_total_bits), 128'(tot_bits));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
